// File: rtl/adder_8bit_pkg.sv
// adder_8bit_pkg: shared width constant for the registered adder
package adder_8bit_pkg;
  localparam int ADDER_WIDTH = 8;
endpackage

// File: rtl/adder_8bit_full_adder.sv
// full_adder: single-bit combinational full adder, one ripple stage
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_8bit.sv
// adder_8bit: ripple-carry adder with carry-in, sum and carry-out registered one cycle
module adder_8bit
  import adder_8bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  assign carry[0] = c;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end
  always_ff @(posedge clk)
    if (rst) {co, s} <= '0;
    else     {co, s} <= {carry[WIDTH], sum};
endmodule

// File: tb/tb_adder_8bit.sv
// tb_adder_8bit: scoreboard bench, driver queues expected {co,s}, monitor checks 1 edge later
module tb_adder_8bit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c = 1'b0;
  logic [7:0] s;
  logic       co;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  typedef struct {
    string      nm;
    logic [8:0] exp;
  } item_t;
  item_t q[$];

  adder_8bit dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .s(s), .co(co));

  always #5 clk = ~clk;

  task automatic drive(input string nm, input logic r, input logic [7:0] aa,
                       input logic [7:0] bb, input logic cc, input logic [8:0] exp);
    @(negedge clk);
    rst = r;
    a = aa;
    b = bb;
    c = cc;
    q.push_back('{nm, exp});
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if ({co, s} !== it.exp) begin
        errors++;
        $display("FAIL %s: got co=%b s=%h, want co=%b s=%h", it.nm, co, s, it.exp[8], it.exp[7:0]);
      end
    end
  end

  logic [7:0] bl [16] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h0F, 8'h10, 8'h3C, 8'h55,
                          8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};

  initial begin
    drive("reset0", 1'b1, 8'h5A, 8'h33, 1'b1, 9'h000);
    drive("reset1", 1'b1, 8'h5A, 8'h33, 1'b1, 9'h000);
    drive("zero", 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    drive("simple1", 1'b0, 8'h01, 8'h00, 1'b0, 9'h001);
    drive("simple2", 1'b0, 8'h01, 8'h01, 1'b0, 9'h002);
    drive("wrap", 1'b0, 8'h01, 8'hFF, 1'b0, 9'h100);
    drive("max", 1'b0, 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    drive("cin", 1'b0, 8'h7F, 8'h00, 1'b1, 9'h080);
    drive("stream0", 1'b0, 8'h10, 8'h20, 1'b0, 9'h030);
    drive("stream1", 1'b0, 8'h80, 8'h80, 1'b0, 9'h100);
    drive("midrst", 1'b1, 8'hAA, 8'h55, 1'b1, 9'h000);
    drive("afterrst", 1'b0, 8'hAA, 8'h55, 1'b1, 9'h100);
    drive("stream2", 1'b0, 8'hC8, 8'h64, 1'b0, 9'h12C);
    drive("stream3", 1'b0, 8'h0F, 8'h01, 1'b1, 9'h011);
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 16; y++)
        for (int z = 0; z < 2; z++)
          drive("sweep", 1'b0, 8'(x), bl[y], 1'(z), 9'(x + int'(bl[y]) + z));
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
